// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port main-memory arbiter.
package mem_arb_pkg;

  localparam int NUM_PORTS  = 2;
  localparam int LINE_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  function automatic logic is_granted(arb_state_t st, logic port);
    return port ? (st == GNT1) : (st == GNT0);
  endfunction

endpackage

// File: rtl/mem_arb_stats.sv
// Grant and wait-cycle counters for the memory port arbiter, 32-bit wrapping.
module mem_arb_stats
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_s0,
  input  logic        req_s1,
  input  arb_state_t  state,
  input  arb_state_t  state_nxt,
  output logic [31:0] grant_count_s0,
  output logic [31:0] grant_count_s1,
  output logic [31:0] wait_cycles_s0,
  output logic [31:0] wait_cycles_s1
);

  logic enter_s0, enter_s1;
  logic wait_s0, wait_s1;

  assign enter_s0 = (state_nxt == GNT0) && (state != GNT0);
  assign enter_s1 = (state_nxt == GNT1) && (state != GNT1);
  assign wait_s0  = req_s0 && !is_granted(state, 1'b0);
  assign wait_s1  = req_s1 && !is_granted(state, 1'b1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_count_s0 <= '0;
      grant_count_s1 <= '0;
      wait_cycles_s0 <= '0;
      wait_cycles_s1 <= '0;
    end else begin
      if (enter_s0) grant_count_s0 <= grant_count_s0 + 32'd1;
      if (enter_s1) grant_count_s1 <= grant_count_s1 + 32'd1;
      if (wait_s0)  wait_cycles_s0 <= wait_cycles_s0 + 32'd1;
      if (wait_s1)  wait_cycles_s1 <= wait_cycles_s1 + 32'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between I-side (0) and D-side (1).
// Optional counter bank enabled by defining ARB_STATS_EN.
//
// state | meaning
// IDLE  | no port owns memory; strobes forced low, both ports see busy
// GNT0  | port 0 owns memory for a whole line transaction
// GNT1  | port 1 owns memory for a whole line transaction
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_s0,
  input  logic              req_s1,
  output logic              gnt_s0,
  output logic              gnt_s1,
  input  logic              wr_s0,
  input  logic              wr_s1,
  input  logic              rd_s0,
  input  logic              rd_s1,
  input  logic [ADDR_W-1:0] addr_s0,
  input  logic [ADDR_W-1:0] addr_s1,
  input  logic [DATA_W-1:0] data_wr_s0,
  input  logic [DATA_W-1:0] data_wr_s1,
  output logic [DATA_W-1:0] data_rd_s0,
  output logic [DATA_W-1:0] data_rd_s1,
  output logic              busy_s0,
  output logic              busy_s1,
  output logic              wr_mem,
  output logic              rd_mem,
  output logic [ADDR_W-1:0] addr_mem,
  output logic [DATA_W-1:0] data_wr_mem,
  input  logic [DATA_W-1:0] data_rd_mem,
  input  logic              busy_mem
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       grant_count_s0,
  output logic [31:0]       grant_count_s1,
  output logic [31:0]       wait_cycles_s0,
  output logic [31:0]       wait_cycles_s1
`endif
);

  arb_state_t state, state_nxt;
  logic       last_gnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == GNT0 && state_nxt != GNT0) last_gnt <= 1'b0;
      if (state == GNT1 && state_nxt != GNT1) last_gnt <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_s0 && req_s1)  state_nxt = last_gnt ? GNT0 : GNT1;
        else if (req_s0)       state_nxt = GNT0;
        else if (req_s1)       state_nxt = GNT1;
      end
      // release hands straight to a waiting port with no idle bubble
      GNT0: if (!req_s0) state_nxt = req_s1 ? GNT1 : IDLE;
      GNT1: if (!req_s1) state_nxt = req_s0 ? GNT0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt_s0 = (state == GNT0);
  assign gnt_s1 = (state == GNT1);

  always_comb begin
    wr_mem      = 1'b0;
    rd_mem      = 1'b0;
    addr_mem    = '0;
    data_wr_mem = '0;
    busy_s0     = 1'b1;
    busy_s1     = 1'b1;
    data_rd_s0  = '0;
    data_rd_s1  = '0;
    case (state)
      GNT0: begin
        wr_mem      = wr_s0;
        rd_mem      = rd_s0;
        addr_mem    = addr_s0;
        data_wr_mem = data_wr_s0;
        busy_s0     = busy_mem;
        data_rd_s0  = data_rd_mem;
      end
      GNT1: begin
        wr_mem      = wr_s1;
        rd_mem      = rd_s1;
        addr_mem    = addr_s1;
        data_wr_mem = data_wr_s1;
        busy_s1     = busy_mem;
        data_rd_s1  = data_rd_mem;
      end
      default: ;
    endcase
  end

`ifdef ARB_STATS_EN
  mem_arb_stats u_stats (
    .clk            (clk),
    .rst            (rst),
    .req_s0         (req_s0),
    .req_s1         (req_s1),
    .state          (state),
    .state_nxt      (state_nxt),
    .grant_count_s0 (grant_count_s0),
    .grant_count_s1 (grant_count_s1),
    .wait_cycles_s0 (wait_cycles_s0),
    .wait_cycles_s1 (wait_cycles_s1)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed line transactions then random traffic.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req [2];
  logic        wr [2];
  logic        rd [2];
  logic [31:0] addr [2];
  logic [31:0] dwr [2];
  logic [31:0] data_rd_mem;
  logic        busy_mem;

  logic        gnt_s0, gnt_s1, busy_s0, busy_s1, wr_mem, rd_mem;
  logic [31:0] data_rd_s0, data_rd_s1, addr_mem, data_wr_mem;
`ifdef ARB_STATS_EN
  logic [31:0] grant_count_s0, grant_count_s1, wait_cycles_s0, wait_cycles_s1;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_s0(req[0]), .req_s1(req[1]),
    .gnt_s0(gnt_s0), .gnt_s1(gnt_s1),
    .wr_s0(wr[0]), .wr_s1(wr[1]),
    .rd_s0(rd[0]), .rd_s1(rd[1]),
    .addr_s0(addr[0]), .addr_s1(addr[1]),
    .data_wr_s0(dwr[0]), .data_wr_s1(dwr[1]),
    .data_rd_s0(data_rd_s0), .data_rd_s1(data_rd_s1),
    .busy_s0(busy_s0), .busy_s1(busy_s1),
    .wr_mem(wr_mem), .rd_mem(rd_mem),
    .addr_mem(addr_mem), .data_wr_mem(data_wr_mem),
    .data_rd_mem(data_rd_mem), .busy_mem(busy_mem)
`ifdef ARB_STATS_EN
    , .grant_count_s0(grant_count_s0), .grant_count_s1(grant_count_s1)
    , .wait_cycles_s0(wait_cycles_s0), .wait_cycles_s1(wait_cycles_s1)
`endif
  );

  typedef struct packed {
    logic        g0, g1, wr, rd;
    logic [31:0] addr, dw;
    logic        b0, b1;
    logic [31:0] dr0, dr1;
`ifdef ARB_STATS_EN
    logic [127:0] stats;
`endif
  } exp_t;

  exp_t exp_q [$];
  int   n_total = 0;
  int   n_pass  = 0;

  // reference model: who owns memory (-1 = nobody) and who owned it last
  int          owner = -1;
  int          last  = 1;
  logic [31:0] gc [2];
  logic [31:0] wc [2];

  task automatic model_step();
    int nxt;
    if (!rst) begin
      owner = -1; last = 1;
      gc[0] = 0; gc[1] = 0; wc[0] = 0; wc[1] = 0;
      return;
    end
    for (int p = 0; p < 2; p++)
      if (req[p] && owner != p) wc[p] = wc[p] + 1;
    nxt = owner;
    if (owner < 0) begin
      if (req[0] && req[1]) nxt = 1 - last;
      else if (req[0])      nxt = 0;
      else if (req[1])      nxt = 1;
    end else if (!req[owner]) begin
      last = owner;
      nxt  = req[1-owner] ? 1 - owner : -1;
    end
    if (nxt >= 0 && nxt != owner) gc[nxt] = gc[nxt] + 1;
    owner = nxt;
  endtask

  task automatic push_exp();
    exp_t e;
    e = '0;
    e.g0 = (owner == 0);
    e.g1 = (owner == 1);
    e.b0 = 1'b1;
    e.b1 = 1'b1;
    if (owner >= 0) begin
      e.wr   = wr[owner];
      e.rd   = rd[owner];
      e.addr = addr[owner];
      e.dw   = dwr[owner];
      if (owner == 0) begin e.b0 = busy_mem; e.dr0 = data_rd_mem; end
      else            begin e.b1 = busy_mem; e.dr1 = data_rd_mem; end
    end
`ifdef ARB_STATS_EN
    e.stats = {gc[0], gc[1], wc[0], wc[1]};
`endif
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(string name, logic [127:0] act, logic [127:0] req_v);
    n_total++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req_v);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("gnt", {126'd0, gnt_s0, gnt_s1}, {126'd0, e.g0, e.g1});
      check("mem_side", {62'd0, wr_mem, rd_mem, addr_mem, data_wr_mem},
            {62'd0, e.wr, e.rd, e.addr, e.dw});
      check("port0", {95'd0, busy_s0, data_rd_s0}, {95'd0, e.b0, e.dr0});
      check("port1", {95'd0, busy_s1, data_rd_s1}, {95'd0, e.b1, e.dr1});
`ifdef ARB_STATS_EN
      check("stats", {grant_count_s0, grant_count_s1, wait_cycles_s0, wait_cycles_s1}, e.stats);
`endif
    end
  end

  task automatic clear_ports();
    for (int p = 0; p < 2; p++) begin
      wr[p] = 0; rd[p] = 0; addr[p] = 0; dwr[p] = 0;
    end
    busy_mem = 0;
  endtask

  initial begin
    int hold [2];
    rst = 0; req[0] = 1; req[1] = 1;
    clear_ports();
    data_rd_mem = 32'h0;
    tick();
    // reset held with both ports requesting
    repeat (2) begin push_exp(); tick(); end
    rst = 1;
    push_exp(); tick();
    // port 0 evict+fill while port 1 attempts a masked write
    for (int i = 0; i < 2*LINE_WORDS; i++) begin
      wr[0] = (i < LINE_WORDS); rd[0] = (i >= LINE_WORDS);
      addr[0] = 32'h0000_0100 + 32'(4*i); dwr[0] = $urandom;
      wr[1] = 1; addr[1] = 32'hDEAD_0000; dwr[1] = $urandom;
      data_rd_mem = $urandom;
      push_exp(); tick();
    end
    repeat (5) begin busy_mem = 1; data_rd_mem = $urandom; push_exp(); tick(); end
    busy_mem = 0;
    req[0] = 0; clear_ports();
    push_exp(); tick();
    // port 1 fill, direct handoff
    for (int i = 0; i < LINE_WORDS; i++) begin
      rd[1] = 1; addr[1] = 32'h0000_1230 + 32'(4*i); data_rd_mem = $urandom;
      push_exp(); tick();
    end
    req[1] = 0; clear_ports();
    push_exp(); tick();
    // alternating ties from idle
    repeat (3) begin
      req[0] = 1; req[1] = 1;
      repeat (3) begin push_exp(); tick(); end
      req[0] = 0; req[1] = 0;
      push_exp(); tick();
    end
    // random traffic with occasional mid-burst reset
    hold[0] = 0; hold[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) != 0);
      for (int p = 0; p < 2; p++) begin
        if (!req[p]) begin
          req[p]  = ($urandom_range(0, 5) == 0);
          hold[p] = $urandom_range(LINE_WORDS, 3*LINE_WORDS);
        end else if (owner == p) begin
          if (hold[p] == 0) req[p] = 0;
          else hold[p]--;
        end
        wr[p] = $urandom_range(0, 1); rd[p] = $urandom_range(0, 1);
        addr[p] = $urandom; dwr[p] = $urandom;
      end
      busy_mem    = ($urandom_range(0, 3) == 0);
      data_rd_mem = $urandom;
      push_exp(); tick();
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
